// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the data memory controller.
package mem_ctrl_pkg;

  // Width of the latched byte address; must match the controller's address width.
  localparam int MEM_ADDR_W = 6;

  // Port identities used for round-robin bookkeeping. Loader encodes as 0 so
  // the all-zero reset state leaves the core first in line.
  localparam logic PORT_LOADER = 1'b0;
  localparam logic PORT_CORE   = 1'b1;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10
  } size_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10,
    ST_RESP  = 2'b11
  } state_t;

  typedef struct packed {
    logic                  we;
    size_t                 size;
    logic                  is_unsigned;
    logic [MEM_ADDR_W-1:0] addr;
    logic [31:0]           wdata;
  } mem_req_t;

  // Number of bytes touched by an access; 0 flags the illegal size code.
  function automatic logic [2:0] access_bytes(input logic [1:0] size);
    logic [2:0] n;
    case (size)
      2'b00:   n = 3'd1;
      2'b01:   n = 3'd2;
      2'b10:   n = 3'd4;
      default: n = 3'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/load_extract.sv
// Big-endian sub-word extraction for loads and byte/half merge for stores.
// The addressed byte always sits in word_i[31:24].
module load_extract
  import mem_ctrl_pkg::*;
(
  input  logic [31:0] word_i,
  input  size_t       size_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merged_o
);

  logic byte_fill_s;
  logic half_fill_s;

  // Sign bit to replicate into the upper bits, forced to 0 for unsigned loads.
  always_comb begin
    byte_fill_s = word_i[31] & ~unsigned_i;
    half_fill_s = word_i[31] & ~unsigned_i;
  end

  // Select the extended load value and the read-modify-write merge per size.
  always_comb begin
    load_o   = 32'h0000_0000;
    merged_o = 32'h0000_0000;
    case (size_i)
      SIZE_BYTE: begin
        load_o   = {{24{byte_fill_s}}, word_i[31:24]};
        merged_o = {wdata_i[7:0], word_i[23:0]};
      end
      SIZE_HALF: begin
        load_o   = {{16{half_fill_s}}, word_i[31:16]};
        merged_o = {wdata_i[15:0], word_i[15:0]};
      end
      SIZE_WORD: begin
        load_o   = word_i;
        merged_o = wdata_i;
      end
      default: begin
        load_o   = 32'h0000_0000;
        merged_o = 32'h0000_0000;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_controller.sv
// Two-port round-robin front-end for the big-endian data memory. Runs byte,
// half and word accesses, turns sub-word stores into read-modify-write, checks
// bounds and returns a one-cycle response pulse to the issuing port.
module data_mem_controller
  import mem_ctrl_pkg::*;
#(
  parameter int memory_size      = 64,
  parameter int memory_addr_size = MEM_ADDR_W
) (
  input  logic                        clk,
  input  logic                        rst,
  // core port
  input  logic                        c_req,
  output logic                        c_ready,
  input  logic                        c_we,
  input  logic [1:0]                  c_size,
  input  logic                        c_unsigned,
  input  logic [memory_addr_size-1:0] c_addr,
  input  logic [31:0]                 c_wdata,
  output logic                        c_rvalid,
  output logic [31:0]                 c_rdata,
  output logic                        c_err,
  // loader port
  input  logic                        l_req,
  output logic                        l_ready,
  input  logic                        l_we,
  input  logic [1:0]                  l_size,
  input  logic                        l_unsigned,
  input  logic [memory_addr_size-1:0] l_addr,
  input  logic [31:0]                 l_wdata,
  output logic                        l_rvalid,
  output logic [31:0]                 l_rdata,
  output logic                        l_err,
  // memory
  output logic [memory_addr_size-1:0] mem_read_reg,
  input  logic [31:0]                 mem_read_data,
  output logic                        mem_write_enable,
  output logic [memory_addr_size-1:0] mem_write_reg,
  output logic [31:0]                 mem_write_data
);

  // End-of-access sum is three bits wider than the address so it never wraps.
  localparam int SUM_W = memory_addr_size + 3;
  localparam logic [SUM_W-1:0] MEM_LIMIT = SUM_W'(memory_size);

  state_t      state_q;
  logic        last_grant_q;
  logic        owner_q;
  mem_req_t    req_q;
  mem_req_t    req_d;
  logic [31:0] data_q;

  logic        c_rvalid_q;
  logic [31:0] c_rdata_q;
  logic        c_err_q;
  logic        l_rvalid_q;
  logic [31:0] l_rdata_q;
  logic        l_err_q;

  logic                        grant_core_s;
  logic                        grant_loader_s;
  logic                        accept_s;
  logic                        sel_we_s;
  logic [1:0]                  sel_size_s;
  logic                        sel_unsigned_s;
  logic [memory_addr_size-1:0] sel_addr_s;
  logic [31:0]                 sel_wdata_s;
  logic [SUM_W-1:0]            end_sum_s;
  logic                        sel_err_s;
  logic [31:0]                 load_word_s;
  logic [31:0]                 merged_word_s;

  // Round-robin grant: only while idle and out of reset; a tie goes to the
  // port that was not granted last.
  always_comb begin
    grant_core_s   = 1'b0;
    grant_loader_s = 1'b0;
    if ((state_q == ST_IDLE) && !rst) begin
      if (c_req && l_req) begin
        if (last_grant_q == PORT_LOADER) begin
          grant_core_s = 1'b1;
        end else begin
          grant_loader_s = 1'b1;
        end
      end else if (c_req) begin
        grant_core_s = 1'b1;
      end else if (l_req) begin
        grant_loader_s = 1'b1;
      end else begin
        grant_core_s   = 1'b0;
        grant_loader_s = 1'b0;
      end
    end else begin
      grant_core_s   = 1'b0;
      grant_loader_s = 1'b0;
    end
  end

  // Mux the granted port's request fields and run the accept-time checks.
  always_comb begin
    accept_s = grant_core_s | grant_loader_s;
    if (grant_loader_s) begin
      sel_we_s       = l_we;
      sel_size_s     = l_size;
      sel_unsigned_s = l_unsigned;
      sel_addr_s     = l_addr;
      sel_wdata_s    = l_wdata;
    end else begin
      sel_we_s       = c_we;
      sel_size_s     = c_size;
      sel_unsigned_s = c_unsigned;
      sel_addr_s     = c_addr;
      sel_wdata_s    = c_wdata;
    end
    end_sum_s = SUM_W'(sel_addr_s) + SUM_W'(access_bytes(sel_size_s));
    sel_err_s = (sel_size_s == 2'b11) || (end_sum_s > MEM_LIMIT);
    req_d.we          = sel_we_s;
    req_d.size        = size_t'(sel_size_s);
    req_d.is_unsigned = sel_unsigned_s;
    req_d.addr        = MEM_ADDR_W'(sel_addr_s);
    req_d.wdata       = sel_wdata_s;
  end

  load_extract u_load_extract (
    .word_i     (mem_read_data),
    .size_i     (req_q.size),
    .unsigned_i (req_q.is_unsigned),
    .wdata_i    (req_q.wdata),
    .load_o     (load_word_s),
    .merged_o   (merged_word_s)
  );

  // Access sequencer: latches the accepted request, walks READ/WRITE and
  // raises the registered response on the issuing port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= PORT_LOADER;
      owner_q      <= PORT_LOADER;
      req_q        <= '0;
      data_q       <= 32'h0000_0000;
      c_rvalid_q   <= 1'b0;
      c_rdata_q    <= 32'h0000_0000;
      c_err_q      <= 1'b0;
      l_rvalid_q   <= 1'b0;
      l_rdata_q    <= 32'h0000_0000;
      l_err_q      <= 1'b0;
    end else begin
      // Response fields are single-cycle pulses unless set below.
      c_rvalid_q <= 1'b0;
      c_rdata_q  <= 32'h0000_0000;
      c_err_q    <= 1'b0;
      l_rvalid_q <= 1'b0;
      l_rdata_q  <= 32'h0000_0000;
      l_err_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            last_grant_q <= grant_loader_s ? PORT_LOADER : PORT_CORE;
            owner_q      <= grant_loader_s ? PORT_LOADER : PORT_CORE;
            if (sel_err_s) begin
              // Erroring requests leave the latched address alone so the
              // memory ports never see the offending address.
              state_q <= ST_RESP;
              if (grant_loader_s) begin
                l_rvalid_q <= 1'b1;
                l_err_q    <= 1'b1;
              end else begin
                c_rvalid_q <= 1'b1;
                c_err_q    <= 1'b1;
              end
            end else begin
              req_q  <= req_d;
              data_q <= sel_wdata_s;
              if (sel_we_s && (sel_size_s == 2'b10)) begin
                state_q <= ST_WRITE;
              end else begin
                state_q <= ST_READ;
              end
            end
          end
        end
        ST_READ: begin
          if (req_q.we) begin
            data_q  <= merged_word_s;
            state_q <= ST_WRITE;
          end else begin
            state_q <= ST_RESP;
            if (owner_q == PORT_LOADER) begin
              l_rvalid_q <= 1'b1;
              l_rdata_q  <= load_word_s;
            end else begin
              c_rvalid_q <= 1'b1;
              c_rdata_q  <= load_word_s;
            end
          end
        end
        ST_WRITE: begin
          state_q <= ST_RESP;
          if (owner_q == PORT_LOADER) begin
            l_rvalid_q <= 1'b1;
          end else begin
            c_rvalid_q <= 1'b1;
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Ready follows the grant; write strobe decodes from state so a reset
  // kills an in-flight write immediately.
  always_comb begin
    c_ready          = grant_core_s;
    l_ready          = grant_loader_s;
    mem_write_enable = (state_q == ST_WRITE);
    mem_read_reg     = memory_addr_size'(req_q.addr);
    mem_write_reg    = memory_addr_size'(req_q.addr);
    mem_write_data   = data_q;
    c_rvalid         = c_rvalid_q;
    c_rdata          = c_rdata_q;
    c_err            = c_err_q;
    l_rvalid         = l_rvalid_q;
    l_rdata          = l_rdata_q;
    l_err            = l_err_q;
  end

endmodule

// File: tb/tb_data_mem_controller.sv
// Scoreboard bench for data_mem_controller: directed requests push expected
// responses; a monitor pops and compares on every rvalid pulse.
module tb_data_mem_controller;

  localparam int MSZ = 64;
  localparam int AW  = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          c_req = 1'b0, c_we = 1'b0, c_unsigned = 1'b0;
  logic [1:0]    c_size = 2'b00;
  logic [AW-1:0] c_addr = '0;
  logic [31:0]   c_wdata = 32'h0;
  logic          l_req = 1'b0, l_we = 1'b0, l_unsigned = 1'b0;
  logic [1:0]    l_size = 2'b00;
  logic [AW-1:0] l_addr = '0;
  logic [31:0]   l_wdata = 32'h0;
  logic          c_ready, c_rvalid, c_err, l_ready, l_rvalid, l_err;
  logic [31:0]   c_rdata, l_rdata;
  logic [AW-1:0] mem_read_reg, mem_write_reg;
  logic [31:0]   mem_read_data, mem_write_data;
  logic          mem_write_enable;

  data_mem_controller #(.memory_size(MSZ), .memory_addr_size(AW)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_ready(c_ready), .c_we(c_we), .c_size(c_size),
    .c_unsigned(c_unsigned), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_rvalid(c_rvalid), .c_rdata(c_rdata), .c_err(c_err),
    .l_req(l_req), .l_ready(l_ready), .l_we(l_we), .l_size(l_size),
    .l_unsigned(l_unsigned), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_rvalid(l_rvalid), .l_rdata(l_rdata), .l_err(l_err),
    .mem_read_reg(mem_read_reg), .mem_read_data(mem_read_data),
    .mem_write_enable(mem_write_enable), .mem_write_reg(mem_write_reg),
    .mem_write_data(mem_write_data)
  );

  always #5 clk = ~clk;

  // Bench-side byte memory, big-endian, out-of-range bytes ignored.
  logic [7:0] mem [0:MSZ-1];
  initial for (int i = 0; i < MSZ; i++) mem[i] = 8'h00;

  always_comb begin
    int idx;
    mem_read_data = 32'h0;
    for (int i = 0; i < 4; i++) begin
      idx = int'(mem_read_reg) + i;
      mem_read_data[31-8*i -: 8] = (idx < MSZ) ? mem[idx] : 8'h00;
    end
  end

  always @(posedge clk) begin
    if (mem_write_enable) begin
      for (int i = 0; i < 4; i++) begin
        if (int'(mem_write_reg) + i < MSZ) mem[int'(mem_write_reg) + i] <= mem_write_data[31-8*i -: 8];
      end
    end
  end

  int cyc = 0;
  int we_count = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (mem_write_enable) we_count <= we_count + 1;

  typedef struct {
    logic        port;   // 1 = core, 0 = loader
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;
  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pop one expectation per response pulse.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (c_rvalid || l_rvalid)) begin
      check("single_port_rvalid", 32'(c_rvalid & l_rvalid), 32'h0);
      if (exp_q.size() == 0) begin
        check("unexpected_rvalid", 32'(1), 32'(0));
      end else begin
        e = exp_q.pop_front();
        check("resp_port", 32'(c_rvalid), 32'(e.port));
        check("resp_rdata", c_rvalid ? c_rdata : l_rdata, e.rdata);
        check("resp_err", 32'(c_rvalid ? c_err : l_err), 32'(e.err));
        check("resp_cycle", 32'(cyc), 32'(e.due));
      end
    end
  end

  task automatic set_port(input logic port, input logic req, input logic we, input logic [1:0] size,
                          input logic uns, input logic [AW-1:0] addr, input logic [31:0] wdata);
    if (port) begin
      c_req = req; c_we = we; c_size = size; c_unsigned = uns; c_addr = addr; c_wdata = wdata;
    end else begin
      l_req = req; l_we = we; l_size = size; l_unsigned = uns; l_addr = addr; l_wdata = wdata;
    end
  endtask

  // Issue one request and, if a response is expected, push it with latency.
  task automatic do_req(input logic port, input logic we, input logic [1:0] size, input logic uns,
                        input logic [AW-1:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err, input int lat,
                        input bit expect_resp);
    bit done;
    exp_t e;
    done = 0;
    set_port(port, 1'b1, we, size, uns, addr, wdata);
    for (int k = 0; k < 30 && !done; k++) begin
      #1;
      if (port ? c_ready : l_ready) begin
        if (expect_resp) begin
          e.port = port; e.rdata = exp_rdata; e.err = exp_err; e.due = cyc + lat;
          exp_q.push_back(e);
        end
        @(posedge clk); #1;
        set_port(port, 1'b0, 1'b0, 2'b00, 1'b0, '0, 32'h0);
        done = 1;
      end else begin
        @(negedge clk);
      end
    end
    if (!done) begin
      check("accept_timeout", 32'(0), 32'(1));
      set_port(port, 1'b0, 1'b0, 2'b00, 1'b0, '0, 32'h0);
    end
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 40 && exp_q.size() != 0; k++) @(negedge clk);
    if (exp_q.size() != 0) begin
      check("resp_timeout", 32'(exp_q.size()), 32'(0));
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_flags"}, 32'({c_ready, l_ready, c_rvalid, l_rvalid, c_err, l_err, mem_write_enable}), 32'h0);
    check({name, "_rdata"}, c_rdata | l_rdata, 32'h0);
    check({name, "_addrs"}, 32'({mem_read_reg, mem_write_reg}), 32'h0);
    check({name, "_wdata"}, mem_write_data, 32'h0);
  endtask

  localparam logic CORE = 1'b1;
  localparam logic LDR  = 1'b0;

  int   wc0;
  int   grants;
  logic [3:0] order;

  initial begin
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Word round-trip.
    do_req(CORE, 1'b1, 2'b10, 1'b0, 6'd4, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1'b1);
    wait_idle();
    check("sw_mem_bytes", {mem[4], mem[5], mem[6], mem[7]}, 32'hDEADBEEF);
    do_req(CORE, 1'b0, 2'b10, 1'b0, 6'd4, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1'b1);
    wait_idle();

    // Sub-word store and extending loads.
    do_req(CORE, 1'b1, 2'b00, 1'b0, 6'd5, 32'h00000012, 32'h0, 1'b0, 3, 1'b1);
    wait_idle();
    check("sb_mem_bytes", {mem[4], mem[5], mem[6], mem[7]}, 32'hDE12BEEF);
    do_req(CORE, 1'b0, 2'b10, 1'b0, 6'd4, 32'h0, 32'hDE12BEEF, 1'b0, 2, 1'b1);
    wait_idle();
    do_req(LDR,  1'b0, 2'b00, 1'b0, 6'd4, 32'h0, 32'hFFFFFFDE, 1'b0, 2, 1'b1);
    wait_idle();
    do_req(CORE, 1'b0, 2'b00, 1'b1, 6'd4, 32'h0, 32'h000000DE, 1'b0, 2, 1'b1);
    wait_idle();
    do_req(LDR,  1'b0, 2'b01, 1'b0, 6'd6, 32'h0, 32'hFFFFBEEF, 1'b0, 2, 1'b1);
    wait_idle();
    do_req(CORE, 1'b0, 2'b01, 1'b1, 6'd6, 32'h0, 32'h0000BEEF, 1'b0, 2, 1'b1);
    wait_idle();

    // Bounds and illegal size: error at accept+1, no memory write.
    wc0 = we_count;
    do_req(CORE, 1'b0, 2'b10, 1'b0, 6'd61, 32'h0, 32'h0, 1'b1, 1, 1'b1);
    wait_idle();
    do_req(LDR,  1'b1, 2'b10, 1'b0, 6'd62, 32'h11223344, 32'h0, 1'b1, 1, 1'b1);
    wait_idle();
    do_req(CORE, 1'b0, 2'b01, 1'b0, 6'd63, 32'h0, 32'h0, 1'b1, 1, 1'b1);
    wait_idle();
    do_req(CORE, 1'b0, 2'b11, 1'b0, 6'd0, 32'h0, 32'h0, 1'b1, 1, 1'b1);
    wait_idle();
    do_req(LDR,  1'b1, 2'b11, 1'b0, 6'd0, 32'hCAFEF00D, 32'h0, 1'b1, 1, 1'b1);
    wait_idle();
    check("err_no_write", 32'(we_count), 32'(wc0));
    check("err_mem_untouched", {mem[60], mem[61], mem[62], mem[63]}, 32'h0);

    do_req(CORE, 1'b1, 2'b00, 1'b0, 6'd63, 32'h000000A5, 32'h0, 1'b0, 3, 1'b1);
    wait_idle();
    do_req(LDR,  1'b0, 2'b10, 1'b0, 6'd60, 32'h0, 32'h000000A5, 1'b0, 2, 1'b1);
    wait_idle();
    do_req(CORE, 1'b0, 2'b00, 1'b1, 6'd63, 32'h0, 32'h000000A5, 1'b0, 2, 1'b1);
    wait_idle();

    // Reset while a byte store sits in READ: write must never happen.
    wc0 = we_count;
    do_req(CORE, 1'b1, 2'b00, 1'b0, 6'd10, 32'h00000077, 32'h0, 1'b0, 0, 1'b0);
    check("rmw_in_read_no_we", 32'(mem_write_enable), 32'h0);
    rst = 1'b1;
    #1;
    check_all_zero("midop_reset");
    // Both ports request from reset for the arbitration check.
    set_port(CORE, 1'b1, 1'b0, 2'b10, 1'b0, 6'd4, 32'h0);
    set_port(LDR,  1'b1, 1'b0, 2'b00, 1'b1, 6'd63, 32'h0);
    repeat (2) @(negedge clk);
    check("midop_no_write", 32'(we_count), 32'(wc0));
    check("midop_byte_kept", 32'(mem[10]), 32'h0);
    rst = 1'b0;

    // Round-robin: core, loader, core, loader.
    grants = 0;
    order  = 4'b0000;
    for (int k = 0; k < 80 && grants < 4; k++) begin
      exp_t e;
      #1;
      check("one_ready", 32'(c_ready & l_ready), 32'h0);
      if (c_ready) begin
        order[grants] = CORE;
        e.port = CORE; e.rdata = 32'hDE12BEEF; e.err = 1'b0; e.due = cyc + 2;
        exp_q.push_back(e);
        grants++;
      end else if (l_ready) begin
        order[grants] = LDR;
        e.port = LDR; e.rdata = 32'h000000A5; e.err = 1'b0; e.due = cyc + 2;
        exp_q.push_back(e);
        grants++;
      end
      if (grants < 4) @(negedge clk);
    end
    @(posedge clk); #1;
    set_port(CORE, 1'b0, 1'b0, 2'b00, 1'b0, '0, 32'h0);
    set_port(LDR,  1'b0, 1'b0, 2'b00, 1'b0, '0, 32'h0);
    check("arb_grant_count", 32'(grants), 32'd4);
    check("arb_order", 32'(order), 32'h5);
    wait_idle();

    // Traffic after reset completes normally.
    do_req(CORE, 1'b1, 2'b00, 1'b0, 6'd10, 32'h00000077, 32'h0, 1'b0, 3, 1'b1);
    wait_idle();
    check("post_reset_sb", 32'(mem[10]), 32'h77);
    do_req(LDR,  1'b0, 2'b00, 1'b1, 6'd10, 32'h0, 32'h00000077, 1'b0, 2, 1'b1);
    wait_idle();

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
